muldiv_arbiter: RTL and testbench

- Shares one DivNbit and one MultNbit instance (both SIZE 33) between NREQ execute-side requesters.
- Only one RV32M operation is in flight at a time, across both units.
- Grants are round-robin. The block formats the 33-bit operands and selects the 32-bit result.
- A per-requester flush cancels that requester's pending or in-flight operation.

---
 rtl/muldiv_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_muldiv_arbiter.sv | 553 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one divider and one multiplier among
// NREQ requesters; one RV32M operation in flight at a time.
module muldiv_arbiter #(
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [5*NREQ-1:0] req_op,
    input  logic [32*NREQ-1:0] req_op1,
    input  logic [32*NREQ-1:0] req_op2,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   flush,
    output logic [NREQ-1:0]   resp_valid,
    output logic [31:0]       resp_data,
    input  logic [NREQ-1:0]   resp_ack,
    output logic              busy,
    output logic              div_start,
    output logic              div_is_signed,
    output logic [32:0]       div_dividend,
    output logic [32:0]       div_divisor,
    input  logic              div_ready,
    input  logic              div_valid,
    input  logic [32:0]       div_quotient,
    input  logic [32:0]       div_remainder,
    output logic              mul_start,
    output logic              mul_is_signed,
    output logic [32:0]       mul_multiplicand,
    output logic [32:0]       mul_multiplier,
    input  logic              mul_ready,
    input  logic              mul_valid,
    input  logic [65:0]       mul_product
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [4:0] ALU_MUL    = 5'd20;
    localparam logic [4:0] ALU_MULH   = 5'd21;
    localparam logic [4:0] ALU_MULHSU = 5'd22;
    localparam logic [4:0] ALU_MULHU  = 5'd23;
    localparam logic [4:0] ALU_DIV    = 5'd24;
    localparam logic [4:0] ALU_DIVU   = 5'd25;
    localparam logic [4:0] ALU_REM    = 5'd26;
    localparam logic [4:0] ALU_REMU   = 5'd27;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_t;

    function automatic logic is_md(input logic [4:0] op);
        return (op >= ALU_MUL) && (op <= ALU_REMU);
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [4:0]      op_q, op_d;
    logic            kill_q, kill_d;
    logic            div_start_q, div_start_d;
    logic            mul_start_q, mul_start_d;
    logic            div_signed_q, div_signed_d;
    logic            mul_signed_q, mul_signed_d;
    logic [32:0]     div_a_q, div_a_d;
    logic [32:0]     div_b_q, div_b_d;
    logic [32:0]     mul_a_q, mul_a_d;
    logic [32:0]     mul_b_q, mul_b_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]     resp_data_q, resp_data_d;

    logic [4:0]      op_l [NREQ];
    logic [31:0]     a_l  [NREQ];
    logic [31:0]     b_l  [NREQ];
    logic [NREQ-1:0] elig;
    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW:0]     cand;
    logic [4:0]      gop;
    logic [31:0]     ga, gb;
    logic            sa, sb;
    logic            tgt_div;
    logic            unit_valid;
    logic [31:0]     result;
    logic            unused_bits;

    assign unused_bits = ^{div_quotient[32], div_remainder[32],
                           mul_product[65:64]};

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign op_l[i] = req_op[5*i +: 5];
        assign a_l[i]  = req_op1[32*i +: 32];
        assign b_l[i]  = req_op2[32*i +: 32];
        assign elig[i] = req_valid[i] && !flush[i] && is_md(op_l[i]);
    end

    // Pick the first eligible lane after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (!grant_found && elig[cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PW-1:0];
            end
        end
    end

    // Format the granted lane's operands to 33 bits.
    always_comb begin
        gop = op_l[grant_idx];
        ga  = a_l[grant_idx];
        gb  = b_l[grant_idx];
        sa  = !(gop == ALU_MULHU || gop == ALU_DIVU || gop == ALU_REMU);
        sb  = (gop == ALU_MUL) || (gop == ALU_MULH) ||
              (gop == ALU_DIV) || (gop == ALU_REM);
    end

    // Select the 32-bit result for the latched operation.
    always_comb begin
        tgt_div    = (op_q >= ALU_DIV);
        unit_valid = tgt_div ? div_valid : mul_valid;
        unique case (op_q)
            ALU_MUL:                         result = mul_product[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: result = mul_product[63:32];
            ALU_DIV, ALU_DIVU:               result = div_quotient[31:0];
            default:                         result = div_remainder[31:0];
        endcase
    end

    // Next-state logic for the arbiter FSM and its registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        op_d         = op_q;
        kill_d       = kill_q;
        div_start_d  = 1'b0;
        mul_start_d  = 1'b0;
        div_signed_d = div_signed_q;
        mul_signed_d = mul_signed_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    op_d    = gop;
                    kill_d  = 1'b0;
                    state_d = ISSUE;
                    if (gop >= ALU_DIV) begin
                        div_a_d      = {sa & ga[31], ga};
                        div_b_d      = {sb & gb[31], gb};
                        div_signed_d = sa;
                    end else begin
                        mul_a_d      = {sa & ga[31], ga};
                        mul_b_d      = {sb & gb[31], gb};
                        mul_signed_d = sa;
                    end
                end
            end
            ISSUE: begin
                if (flush[owner_q]) begin
                    state_d = IDLE;
                end else if (tgt_div ? div_ready : mul_ready) begin
                    div_start_d = tgt_div;
                    mul_start_d = !tgt_div;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (flush[owner_q]) kill_d = 1'b1;
                if (unit_valid && !(div_start_q || mul_start_q)) begin
                    if (kill_q || flush[owner_q]) begin
                        kill_d  = 1'b0;
                        ptr_d   = owner_q;
                        state_d = IDLE;
                    end else begin
                        resp_data_d           = result;
                        resp_valid_d[owner_q] = 1'b1;
                        state_d               = RESP;
                    end
                end
            end
            RESP: begin
                if (flush[owner_q] || resp_ack[owner_q]) begin
                    resp_valid_d = '0;
                    ptr_d        = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= PW'(NREQ - 1);
            op_q         <= '0;
            kill_q       <= 1'b0;
            div_start_q  <= 1'b0;
            mul_start_q  <= 1'b0;
            div_signed_q <= 1'b0;
            mul_signed_q <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            op_q         <= op_d;
            kill_q       <= kill_d;
            div_start_q  <= div_start_d;
            mul_start_q  <= mul_start_d;
            div_signed_q <= div_signed_d;
            mul_signed_q <= mul_signed_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Accept strobe is only offered in IDLE and never while in reset.
    assign req_ready = (state_q == IDLE && rst_n && grant_found)
                     ? (NREQ'(1) << grant_idx) : '0;

    assign busy             = (state_q != IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign div_start        = div_start_q;
    assign div_is_signed    = div_signed_q;
    assign div_dividend     = div_a_q;
    assign div_divisor      = div_b_q;
    assign mul_start        = mul_start_q;
    assign mul_is_signed    = mul_signed_q;
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Testbench for muldiv_arbiter with behavioural divider/multiplier
// models and a queue of expected responses.
module tb_muldiv_arbiter;

    localparam logic [4:0] ALU_MUL    = 5'd20;
    localparam logic [4:0] ALU_MULH   = 5'd21;
    localparam logic [4:0] ALU_MULHSU = 5'd22;
    localparam logic [4:0] ALU_MULHU  = 5'd23;
    localparam logic [4:0] ALU_DIV    = 5'd24;
    localparam logic [4:0] ALU_DIVU   = 5'd25;
    localparam logic [4:0] ALU_REM    = 5'd26;
    localparam logic [4:0] ALU_REMU   = 5'd27;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 5;

    typedef struct packed {
        logic [1:0]  lane;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [9:0]  req_op;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [1:0]  req_ready;
    logic [1:0]  flush;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [1:0]  resp_ack;
    logic        busy;
    logic        div_start, div_is_signed;
    logic [32:0] div_dividend, div_divisor;
    logic        div_ready = 1'b1;
    logic        div_valid = 1'b0;
    logic [32:0] div_quotient = '0;
    logic [32:0] div_remainder = '0;
    logic        mul_start, mul_is_signed;
    logic [32:0] mul_multiplicand, mul_multiplier;
    logic        mul_ready = 1'b1;
    logic        mul_valid = 1'b0;
    logic [65:0] mul_product = '0;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mul_starts = 0;
    int   div_starts = 0;
    int   start_cyc = 0;
    int   valid_cyc = 0;
    int   resp_cyc = 0;
    int   resp_rises = 0;
    int   multi_ready = 0;
    int   mul_cnt = 0;
    int   div_cnt = 0;
    logic [1:0] prev_rv = '0;
    exp_t exp_q[$];

    assign resp_ack = resp_valid;

    muldiv_arbiter #(.NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op),
        .req_op1(req_op1), .req_op2(req_op2),
        .req_ready(req_ready), .flush(flush),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ack(resp_ack), .busy(busy),
        .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_valid(div_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .mul_start(mul_start), .mul_is_signed(mul_is_signed),
        .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier),
        .mul_ready(mul_ready), .mul_valid(mul_valid),
        .mul_product(mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: fixed latency, result from the 33-bit operands.
    always @(posedge clk) begin
        mul_valid <= 1'b0;
        if (mul_cnt != 0) begin
            mul_cnt <= mul_cnt - 1;
            if (mul_cnt == 1) begin
                mul_valid <= 1'b1;
                mul_ready <= 1'b1;
            end
        end else if (mul_start) begin
            mul_ready <= 1'b0;
            mul_cnt   <= MUL_LAT;
            if (mul_is_signed)
                mul_product <= {{33{mul_multiplicand[32]}}, mul_multiplicand}
                             * {{33{mul_multiplier[32]}}, mul_multiplier};
            else
                mul_product <= {33'b0, mul_multiplicand}
                             * {33'b0, mul_multiplier};
        end
    end

    // Divider model.
    always @(posedge clk) begin
        div_valid <= 1'b0;
        if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 1) begin
                div_valid <= 1'b1;
                div_ready <= 1'b1;
            end
        end else if (div_start) begin
            div_ready <= 1'b0;
            div_cnt   <= DIV_LAT;
            if (div_is_signed) begin
                div_quotient  <= $signed(div_dividend) / $signed(div_divisor);
                div_remainder <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                div_quotient  <= div_dividend / div_divisor;
                div_remainder <= div_dividend % div_divisor;
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start) begin mul_starts++; start_cyc = cyc; end
        if (div_start) begin div_starts++; start_cyc = cyc; end
        if (mul_valid || div_valid) valid_cyc = cyc;
        if (resp_valid != 2'b00 && prev_rv == 2'b00) begin
            resp_rises++;
            resp_cyc = cyc;
        end
        prev_rv = resp_valid;
    end

    always @(negedge clk) begin
        #2;
        if (!$onehot0(req_ready)) multi_ready++;
    end

    function automatic logic [31:0] ref_md(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        p = '0;
        r = '0;
        case (op)
            ALU_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            ALU_DIV:    r = $signed(a) / $signed(b);
            ALU_DIVU:   r = a / b;
            ALU_REM:    r = $signed(a) % $signed(b);
            ALU_REMU:   r = a % b;
            default:    r = '0;
        endcase
        return r;
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        e = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    task automatic set_lane(input int lane, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        req_valid[lane]       = 1'b1;
        req_op[5*lane +: 5]   = op;
        req_op1[32*lane +: 32] = a;
        req_op2[32*lane +: 32] = b;
    endtask

    task automatic issue_one(input int lane, input logic [4:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit push, output int acc_cyc);
        bit got;
        got = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        set_lane(lane, op, a, b);
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (req_ready[lane]) begin
                got = 1'b1;
                acc_cyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout lane=%0d", lane);
        end else if (push) begin
            exp_q.push_back(exp_t'{2'(1 << lane), ref_md(op, a, b)});
        end
        @(posedge clk);
        #1;
        req_valid[lane] = 1'b0;
    endtask

    task automatic wait_resp(output logic [1:0] v, output logic [31:0] d);
        bit got;
        got = 1'b0;
        v = '0;
        d = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (resp_valid != 2'b00) begin
                got = 1'b1;
                v = resp_valid;
                d = resp_data;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout");
        end
        #1;
    endtask

    task automatic wait_start();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mul_start || div_start) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL start_timeout");
        end
    endtask

    task automatic test_reset();
        logic [172:0] outs;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        outs = {req_ready, resp_valid, resp_data, busy, div_start,
                div_is_signed, div_dividend, div_divisor, mul_start,
                mul_is_signed, mul_multiplicand, mul_multiplier};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        set_lane(0, ALU_MUL, 32'd1, 32'd1);
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready got=%b want=00", req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int acc;
        int s0;
        logic [1:0] v;
        logic [31:0] d;
        exp_t e;
        s0 = mul_starts;
        issue_one(0, ALU_MUL, 32'd3, 32'hFFFF_FFFC, 1'b1, acc);
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data) begin
            failures++;
            $display("FAIL mul_resp got=%b/%h want=%b/%h", v, d, e.lane, e.data);
        end
        checks++;
        if (d !== 32'hFFFF_FFF4) begin
            failures++;
            $display("FAIL mul_value got=%h want=fffffff4", d);
        end
        checks++;
        if (mul_multiplicand !== 33'h0_0000_0003 ||
            mul_multiplier !== 33'h1_FFFF_FFFC || mul_is_signed !== 1'b1) begin
            failures++;
            $display("FAIL mul_operands got=%h/%h/%b want=000000003/1fffffffc/1",
                     mul_multiplicand, mul_multiplier, mul_is_signed);
        end
        checks++;
        if (mul_starts - s0 != 1) begin
            failures++;
            $display("FAIL mul_start_count got=%0d want=1", mul_starts - s0);
        end
        checks++;
        if (start_cyc - acc != 2) begin
            failures++;
            $display("FAIL start_latency got=%0d want=2", start_cyc - acc);
        end
        checks++;
        if (resp_cyc - valid_cyc != 1) begin
            failures++;
            $display("FAIL resp_latency got=%0d want=1", resp_cyc - valid_cyc);
        end
    endtask

    task automatic test_mulhsu();
        int acc;
        logic [1:0] v;
        logic [31:0] d;
        exp_t e;
        issue_one(1, ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, acc);
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data) begin
            failures++;
            $display("FAIL mulhsu_resp got=%b/%h want=%b/%h", v, d, e.lane, e.data);
        end
        checks++;
        if (mul_multiplier !== 33'h0_FFFF_FFFF ||
            mul_multiplicand !== 33'h1_FFFF_FFFF || mul_is_signed !== 1'b1) begin
            failures++;
            $display("FAIL mulhsu_operands got=%h/%h/%b want=1ffffffff/0ffffffff/1",
                     mul_multiplicand, mul_multiplier, mul_is_signed);
        end
    endtask

    task automatic test_round_robin();
        int ng, nr, s0, m0;
        logic [7:0] seq;
        exp_t e;
        ng = 0;
        nr = 0;
        s0 = div_starts;
        m0 = multi_ready;
        seq = '0;
        @(negedge clk);
        set_lane(0, ALU_DIV, 32'd100, 32'd7);
        set_lane(1, ALU_DIV, -32'sd100, 32'd7);
        for (int i = 0; i < 400 && nr < 4; i++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin
                seq = {seq[5:0], req_ready};
                if (req_ready[1])
                    exp_q.push_back(exp_t'{2'b10, ref_md(ALU_DIV, -32'sd100, 32'd7)});
                else
                    exp_q.push_back(exp_t'{2'b01, ref_md(ALU_DIV, 32'd100, 32'd7)});
                ng++;
                if (ng == 4) begin
                    @(posedge clk);
                    #1;
                    req_valid = '0;
                end
            end
            if (resp_valid != 2'b00) begin
                e = pop_exp();
                nr++;
                checks++;
                if (resp_valid !== e.lane || resp_data !== e.data) begin
                    failures++;
                    $display("FAIL rr_resp%0d got=%b/%h want=%b/%h",
                             nr, resp_valid, resp_data, e.lane, e.data);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        checks++;
        if (nr != 4) begin
            failures++;
            $display("FAIL rr_count got=%0d want=4", nr);
        end
        checks++;
        if (seq !== 8'b01_10_01_10) begin
            failures++;
            $display("FAIL rr_order got=%b want=01100110", seq);
        end
        checks++;
        if (div_starts - s0 != 4) begin
            failures++;
            $display("FAIL rr_starts got=%0d want=4", div_starts - s0);
        end
        checks++;
        if (multi_ready != m0) begin
            failures++;
            $display("FAIL rr_onehot got=%0d want=0", multi_ready - m0);
        end
    endtask

    task automatic test_divu();
        int acc;
        logic [1:0] v;
        logic [31:0] d;
        exp_t e;
        issue_one(0, ALU_DIVU, 32'd7, 32'd2, 1'b1, acc);
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data || d !== 32'd3) begin
            failures++;
            $display("FAIL divu_resp got=%b/%h want=%b/%h", v, d, e.lane, e.data);
        end
        checks++;
        if (div_is_signed !== 1'b0 || div_dividend !== 33'd7 ||
            div_divisor !== 33'd2) begin
            failures++;
            $display("FAIL divu_operands got=%b/%h/%h want=0/7/2",
                     div_is_signed, div_dividend, div_divisor);
        end
        issue_one(0, ALU_REMU, 32'd7, 32'd2, 1'b1, acc);
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data || d !== 32'd1) begin
            failures++;
            $display("FAIL remu_resp got=%b/%h want=%b/%h", v, d, e.lane, e.data);
        end
    endtask

    task automatic test_flush();
        int acc, acc1, r0;
        bit got;
        logic [1:0] v;
        logic [31:0] d;
        exp_t e;
        got = 1'b0;
        acc1 = 0;
        issue_one(0, ALU_DIV, 32'd50, 32'd5, 1'b0, acc);
        set_lane(1, ALU_DIVU, 32'd9, 32'd4);
        wait_start();
        @(negedge clk);
        flush[0] = 1'b1;
        r0 = resp_rises;
        @(negedge clk);
        flush[0] = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (req_ready[1]) begin
                got = 1'b1;
                acc1 = cyc;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!got || acc1 - valid_cyc != 1) begin
            failures++;
            $display("FAIL flush_next_grant got=%0d want=1", acc1 - valid_cyc);
        end
        checks++;
        if (resp_rises != r0) begin
            failures++;
            $display("FAIL flush_no_resp got=%0d want=0", resp_rises - r0);
        end
        exp_q.push_back(exp_t'{2'b10, ref_md(ALU_DIVU, 32'd9, 32'd4)});
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data) begin
            failures++;
            $display("FAIL flush_other_resp got=%b/%h want=%b/%h",
                     v, d, e.lane, e.data);
        end
    endtask

    task automatic test_reset_busy();
        int acc, r0;
        logic [1:0] v;
        logic [31:0] d;
        logic [172:0] outs;
        exp_t e;
        issue_one(0, ALU_MUL, 32'd6, 32'd7, 1'b1, acc);
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data) begin
            failures++;
            $display("FAIL pre_reset_resp got=%b/%h want=%b/%h", v, d, e.lane, e.data);
        end
        issue_one(1, ALU_MULH, 32'd5, 32'd5, 1'b0, acc);
        wait_start();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        outs = {req_ready, resp_valid, resp_data, busy, div_start,
                div_is_signed, div_dividend, div_divisor, mul_start,
                mul_is_signed, mul_multiplicand, mul_multiplier};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%h want=0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        r0 = resp_rises;
        repeat (10) @(negedge clk);
        checks++;
        if (resp_rises != r0) begin
            failures++;
            $display("FAIL stale_valid_resp got=%0d want=0", resp_rises - r0);
        end
        set_lane(0, ALU_MUL, 32'd9, 32'd9);
        set_lane(1, ALU_MUL, 32'd2, 32'd2);
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_grant got=%b want=01", req_ready);
        end
        exp_q.push_back(exp_t'{2'b01, ref_md(ALU_MUL, 32'd9, 32'd9)});
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_resp(v, d);
        e = pop_exp();
        checks++;
        if (v !== e.lane || d !== e.data) begin
            failures++;
            $display("FAIL post_reset_resp got=%b/%h want=%b/%h",
                     v, d, e.lane, e.data);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_op1   = '0;
        req_op2   = '0;
        flush     = '0;
        test_reset();
        test_mul();
        test_mulhsu();
        test_round_robin();
        test_divu();
        test_flush();
        test_reset_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
